// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Purpose  : Shared definitions for the 2D DMA engine: FSM state encoding,
//            swap_mode codes and the per-word byte transformation.
// Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

    // FSM state encoding
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD      = 3'd1;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd2;
    localparam logic [2:0] c_ST_WR      = 3'd3;
    localparam logic [2:0] c_ST_WR_WAIT = 3'd4;
    localparam logic [2:0] c_ST_FIN     = 3'd5;

    // swap_mode codes
    localparam logic [1:0] c_SWAP_NONE = 2'b00;
    localparam logic [1:0] c_SWAP_HALF = 2'b01;
    localparam logic [1:0] c_SWAP_REV  = 2'b10;
    localparam logic [1:0] c_SWAP_ODD  = 2'b11;

    // Byte transform of one data word. The word is carried in 64 bits so one
    // function serves both data widths; nbytes is the live width in bytes.
    // Halfword swap exchanges the two bytes of every 16-bit lane; full
    // reverse mirrors the live bytes end to end.
    function automatic logic [63:0] byte_swap(
        input logic [63:0] data,
        input logic [1:0]  mode,
        input logic        odd_row,
        input int          nbytes
    );
        logic [63:0] res;
        logic        half;
        res  = data;
        half = (mode == c_SWAP_HALF) || ((mode == c_SWAP_ODD) && odd_row);
        for (int i = 0; i < 8; i++) begin
            if (half) begin
                res[i*8 +: 8] = data[(i ^ 1)*8 +: 8];
            end else if ((mode == c_SWAP_REV) && (i < nbytes)) begin
                res[i*8 +: 8] = data[(nbytes - 1 - i)*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_burst_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dma_burst_fifo
// Purpose  : Synchronous FIFO holding one burst of read data between the read
//            and write phases of the DMA engine.
// Ports    : clk, rst (sync, active-high), flush (empties the FIFO),
//            push/push_data (write side), pop/pop_data (read side, pop_data
//            shows the head entry), empty, full.
// Revision : 1.0 - initial release
// ============================================================================
module dma_burst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int c_PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to separate full from empty.
    logic [c_PW:0]      wr_ptr_q, wr_ptr_d;
    logic [c_PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               w_push_ok;
    logic               w_pop_ok;

    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[c_PW] != rd_ptr_q[c_PW]) &&
                    (wr_ptr_q[c_PW-1:0] == rd_ptr_q[c_PW-1:0]);
        w_push_ok = push && !full && !flush;
        w_pop_ok  = pop && !empty && !flush;
        wr_ptr_d  = flush ? '0 : wr_ptr_q + {{c_PW{1'b0}}, w_push_ok};
        rd_ptr_d  = flush ? '0 : rd_ptr_q + {{c_PW{1'b0}}, w_pop_ok};
        pop_data  = mem_q[rd_ptr_q[c_PW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q[c_PW-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_2d_engine.sv
`default_nettype none
// ============================================================================
// Module   : dma_2d_engine
// Purpose  : 2D (rows x line) memory copy engine over an ICB master port.
//            Each line is moved in bursts of up to BURST words: read burst,
//            buffer, write burst with optional byte swapping.
// Ports    : clk, rst; cfg (start, src/dst addr, line_bytes, rows, strides,
//            swap_mode, irq_clr); ICB cmd/rsp master channels; status
//            (busy, done, err, dma_irq).
// Revision : 1.0 - initial release
// ============================================================================
module dma_2d_engine #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   src_addr,
    input  logic [AW-1:0]   dst_addr,
    input  logic [15:0]     line_bytes,
    input  logic [15:0]     rows,
    input  logic [AW-1:0]   src_stride,
    input  logic [AW-1:0]   dst_stride,
    input  logic [1:0]      swap_mode,
    input  logic            irq_clr,
    output logic            dma_icb_cmd_valid,
    input  logic            dma_icb_cmd_ready,
    output logic [AW-1:0]   dma_icb_cmd_addr,
    output logic            dma_icb_cmd_read,
    output logic [DW-1:0]   dma_icb_cmd_wdata,
    output logic [DW/8-1:0] dma_icb_cmd_wmask,
    input  logic            dma_icb_rsp_valid,
    output logic            dma_icb_rsp_ready,
    input  logic            dma_icb_rsp_err,
    input  logic [DW-1:0]   dma_icb_rsp_rdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            dma_irq
);
    import dma_pkg::*;

    localparam int c_BYTES  = DW / 8;
    localparam int c_BSHIFT = (DW == 64) ? 3 : 2;
    localparam int c_CW     = $clog2(BURST) + 1;

    logic [2:0]      state_q, state_d;
    logic [AW-1:0]   src_base_q, src_base_d;
    logic [AW-1:0]   dst_base_q, dst_base_d;
    logic [AW-1:0]   src_stride_q, src_stride_d;
    logic [AW-1:0]   dst_stride_q, dst_stride_d;
    logic [15:0]     words_q, words_d;
    logic [15:0]     rows_q, rows_d;
    logic [15:0]     row_idx_q, row_idx_d;
    logic [15:0]     word_off_q, word_off_d;
    logic [1:0]      swap_q, swap_d;
    logic [c_CW-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [c_CW-1:0] rsp_cnt_q, rsp_cnt_d;
    logic            abort_q, abort_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [15:0]     w_rem;
    logic [c_CW-1:0] w_burst_n;
    logic            w_last_cmd;
    logic            w_last_rsp;
    logic            w_line_end;
    logic            w_cmd_fire;
    logic [AW-1:0]   w_byte_off;
    logic [15:0]     w_start_words;
    logic            w_fifo_flush;
    logic            w_fifo_push;
    logic            w_fifo_pop;
    logic [DW-1:0]   w_fifo_data;
    logic            w_fifo_empty;
    logic            w_fifo_full;

    dma_burst_fifo #(
        .DEPTH (BURST),
        .WIDTH (DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_fifo_flush),
        .push      (w_fifo_push),
        .push_data (dma_icb_rsp_rdata),
        .pop       (w_fifo_pop),
        .pop_data  (w_fifo_data),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

    // Burst length is derived from the line position, which only moves at
    // burst end, so it is stable throughout a read/write burst pair.
    always_comb begin
        w_rem         = words_q - word_off_q;
        w_burst_n     = (w_rem > 16'(BURST)) ? c_CW'(BURST) : w_rem[c_CW-1:0];
        w_last_cmd    = (cmd_cnt_q == w_burst_n - c_CW'(1));
        w_last_rsp    = (rsp_cnt_q == w_burst_n - c_CW'(1));
        w_line_end    = ((word_off_q + 16'(w_burst_n)) == words_q);
        w_byte_off    = AW'(word_off_q + 16'(cmd_cnt_q)) << c_BSHIFT;
        w_start_words = line_bytes >> c_BSHIFT;
        w_cmd_fire    = dma_icb_cmd_valid && dma_icb_cmd_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_ST_IDLE;
            src_base_q   <= '0;
            dst_base_q   <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            words_q      <= '0;
            rows_q       <= '0;
            row_idx_q    <= '0;
            word_off_q   <= '0;
            swap_q       <= '0;
            cmd_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
            abort_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_base_q   <= src_base_d;
            dst_base_q   <= dst_base_d;
            src_stride_q <= src_stride_d;
            dst_stride_q <= dst_stride_d;
            words_q      <= words_d;
            rows_q       <= rows_d;
            row_idx_q    <= row_idx_d;
            word_off_q   <= word_off_d;
            swap_q       <= swap_d;
            cmd_cnt_q    <= cmd_cnt_d;
            rsp_cnt_q    <= rsp_cnt_d;
            abort_q      <= abort_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        src_base_d   = src_base_q;
        dst_base_d   = dst_base_q;
        src_stride_d = src_stride_q;
        dst_stride_d = dst_stride_q;
        words_d      = words_q;
        rows_d       = rows_q;
        row_idx_d    = row_idx_q;
        word_off_d   = word_off_q;
        swap_d       = swap_q;
        cmd_cnt_d    = cmd_cnt_q;
        rsp_cnt_d    = rsp_cnt_q;
        abort_d      = abort_q;
        done_d       = done_q;
        err_d        = err_q;
        w_fifo_flush = 1'b0;
        w_fifo_push  = 1'b0;
        w_fifo_pop   = 1'b0;

        if (irq_clr) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end

        case (state_q)
            c_ST_IDLE: begin
                if (start) begin
                    src_base_d   = src_addr;
                    dst_base_d   = dst_addr;
                    src_stride_d = src_stride;
                    dst_stride_d = dst_stride;
                    words_d      = w_start_words;
                    rows_d       = rows;
                    swap_d       = swap_mode;
                    row_idx_d    = '0;
                    word_off_d   = '0;
                    cmd_cnt_d    = '0;
                    rsp_cnt_d    = '0;
                    abort_d      = 1'b0;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    w_fifo_flush = 1'b1;
                    state_d      = ((w_start_words == '0) || (rows == '0)) ? c_ST_FIN : c_ST_RD;
                end
            end
            c_ST_RD, c_ST_WR: begin
                if (w_cmd_fire) begin
                    w_fifo_pop = (state_q == c_ST_WR);
                    if (w_last_cmd) begin
                        cmd_cnt_d = '0;
                        state_d   = (state_q == c_ST_RD) ? c_ST_RD_WAIT : c_ST_WR_WAIT;
                    end else begin
                        cmd_cnt_d = cmd_cnt_q + c_CW'(1);
                    end
                end
            end
            c_ST_RD_WAIT, c_ST_WR_WAIT: begin
                if (dma_icb_rsp_valid) begin
                    // After an error the rest of the burst is drained but dropped.
                    w_fifo_push = (state_q == c_ST_RD_WAIT) && !dma_icb_rsp_err &&
                                  !abort_q && !w_fifo_full;
                    if (dma_icb_rsp_err) begin
                        abort_d = 1'b1;
                        err_d   = 1'b1;
                    end
                    if (!w_last_rsp) begin
                        rsp_cnt_d = rsp_cnt_q + c_CW'(1);
                    end else begin
                        rsp_cnt_d = '0;
                        if (abort_q || dma_icb_rsp_err) begin
                            state_d = c_ST_FIN;
                        end else if (state_q == c_ST_RD_WAIT) begin
                            state_d = c_ST_WR;
                        end else if (w_line_end) begin
                            word_off_d = '0;
                            row_idx_d  = row_idx_q + 16'd1;
                            src_base_d = src_base_q + src_stride_q;
                            dst_base_d = dst_base_q + dst_stride_q;
                            state_d    = (row_idx_q == rows_q - 16'd1) ? c_ST_FIN : c_ST_RD;
                        end else begin
                            word_off_d = word_off_q + 16'(w_burst_n);
                            state_d    = c_ST_RD;
                        end
                    end
                end
            end
            c_ST_FIN: begin
                done_d  = !abort_q;
                state_d = c_ST_IDLE;
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        dma_icb_cmd_valid = 1'b0;
        dma_icb_cmd_read  = 1'b0;
        dma_icb_cmd_addr  = '0;
        dma_icb_cmd_wdata = '0;
        dma_icb_cmd_wmask = '0;
        dma_icb_rsp_ready = 1'b0;
        case (state_q)
            c_ST_RD: begin
                dma_icb_cmd_valid = 1'b1;
                dma_icb_cmd_read  = 1'b1;
                dma_icb_cmd_addr  = src_base_q + w_byte_off;
            end
            c_ST_WR: begin
                dma_icb_cmd_valid = !w_fifo_empty;
                dma_icb_cmd_addr  = dst_base_q + w_byte_off;
                dma_icb_cmd_wdata = DW'(byte_swap(64'(w_fifo_data), swap_q,
                                                  row_idx_q[0], c_BYTES));
                dma_icb_cmd_wmask = '1;
            end
            c_ST_RD_WAIT, c_ST_WR_WAIT: begin
                dma_icb_rsp_ready = 1'b1;
            end
            default: ;
        endcase
        busy    = (state_q != c_ST_IDLE) && (state_q != c_ST_FIN);
        done    = done_q;
        err     = err_q;
        dma_irq = done_q | err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_2d_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_2d_engine
// Purpose  : Self-checking bench for dma_2d_engine. A memory-slave model
//            answers ICB commands; a reference model predicts the full command
//            stream of each transfer into a scoreboard queue that a monitor
//            consumes on every command handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_2d_engine;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst, start, irq_clr;
    logic [31:0] src_addr, dst_addr, src_stride, dst_stride;
    logic [15:0] line_bytes, rows;
    logic [1:0]  swap_mode;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy, done, err, irq;

    always #5 clk = ~clk;

    dma_2d_engine #(.AW(AW), .DW(DW), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr),
        .line_bytes(line_bytes), .rows(rows),
        .src_stride(src_stride), .dst_stride(dst_stride),
        .swap_mode(swap_mode), .irq_clr(irq_clr),
        .dma_icb_cmd_valid(cmd_valid), .dma_icb_cmd_ready(cmd_ready),
        .dma_icb_cmd_addr(cmd_addr), .dma_icb_cmd_read(cmd_read),
        .dma_icb_cmd_wdata(cmd_wdata), .dma_icb_cmd_wmask(cmd_wmask),
        .dma_icb_rsp_valid(rsp_valid), .dma_icb_rsp_ready(rsp_ready),
        .dma_icb_rsp_err(rsp_err), .dma_icb_rsp_rdata(rsp_rdata),
        .busy(busy), .done(done), .err(err), .dma_irq(irq)
    );

    typedef struct packed { logic rd; logic [31:0] addr; logic [31:0] data; } exp_t;
    typedef struct packed { logic e; logic [31:0] d; } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    checks = 0;
    int    errors = 0;
    int    rd_seen = 0, wr_seen = 0, stall_checks = 0;
    int    err_read_idx = -1;
    int    read_idx = 0;
    int    force_stall = 0;
    bit    const_data = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return const_data ? 32'h1122_3344 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    // Byte view of the transform: b[0] is the least significant byte.
    function automatic logic [31:0] ref_swap(input logic [31:0] w, input logic [1:0] mode, input bit odd);
        logic [7:0] b[4];
        logic [7:0] o[4];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        for (int i = 0; i < 4; i++) o[i] = b[i];
        if (mode == 2'b01 || (mode == 2'b11 && odd)) begin
            o[0] = b[1]; o[1] = b[0]; o[2] = b[3]; o[3] = b[2];
        end else if (mode == 2'b10) begin
            for (int i = 0; i < 4; i++) o[i] = b[3-i];
        end
        return {o[3], o[2], o[1], o[0]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Memory slave: accepts commands, queues responses in order.
    initial begin
        bit    held;
        pend_t p;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
        forever begin
            @(negedge clk);
            held = 1'b0;
            if (rst) begin
                pend_q.delete();
            end else begin
                if (rsp_valid && rsp_ready) void'(pend_q.pop_front());
                else held = rsp_valid;
                if (cmd_valid && cmd_ready) begin
                    p.e = cmd_read && (read_idx == err_read_idx);
                    p.d = cmd_read ? mem_word(cmd_addr) : 32'h0;
                    if (cmd_read) read_idx++;
                    pend_q.push_back(p);
                end
            end
            @(posedge clk); #1;
            if (force_stall > 0) begin
                cmd_ready = 1'b0;
                if (cmd_valid) force_stall--;
            end else begin
                cmd_ready = ($urandom_range(0, 3) != 0);
            end
            if (pend_q.size() > 0 && (held || $urandom_range(0, 2) != 0)) begin
                rsp_valid = 1'b1; rsp_err = pend_q[0].e; rsp_rdata = pend_q[0].d;
            end else begin
                rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
            end
        end
    end

    // Monitor: command stability under backpressure and scoreboard compare.
    initial begin
        bit          stalled;
        logic [31:0] s_addr, s_wdata;
        logic        s_read;
        exp_t        e;
        stalled = 1'b0; s_addr = '0; s_wdata = '0; s_read = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++; stall_checks++;
                    if (!cmd_valid || cmd_addr !== s_addr || cmd_read !== s_read || cmd_wdata !== s_wdata) begin
                        errors++;
                        $display("FAIL stall_hold actual v=%0b a=%0h r=%0b d=%0h required v=1 a=%0h r=%0b d=%0h",
                                 cmd_valid, cmd_addr, cmd_read, cmd_wdata, s_addr, s_read, s_wdata);
                    end
                end
                stalled = cmd_valid && !cmd_ready;
                s_addr = cmd_addr; s_read = cmd_read; s_wdata = cmd_wdata;
                if (cmd_valid && cmd_ready) begin
                    if (cmd_read) rd_seen++; else wr_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_cmd actual r=%0b a=%0h d=%0h required none", cmd_read, cmd_addr, cmd_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (cmd_read !== e.rd || cmd_addr !== e.addr ||
                            (!e.rd && (cmd_wdata !== e.data || cmd_wmask !== 4'hF))) begin
                            errors++;
                            $display("FAIL cmd actual r=%0b a=%0h d=%0h m=%0h required r=%0b a=%0h d=%0h m=f",
                                     cmd_read, cmd_addr, cmd_wdata, cmd_wmask, e.rd, e.addr, e.data);
                        end
                    end
                end
            end
        end
    end

    // Reference model: predicts the full command stream of a transfer.
    task automatic predict(input logic [31:0] s, d, input logic [15:0] lb, r,
                           input logic [31:0] ss, ds, input logic [1:0] sw, input int err_idx);
        int   words, n, ridx;
        bit   stop;
        exp_t e;
        logic [31:0] ra;
        words = int'(lb) / 4; ridx = 0; stop = 1'b0;
        for (int row = 0; row < int'(r) && !stop; row++) begin
            for (int w = 0; w < words && !stop; w += n) begin
                n = (words - w < BURST) ? words - w : BURST;
                for (int k = 0; k < n; k++) begin
                    e.rd = 1'b1; e.addr = s + 32'(row) * ss + 32'(w + k) * 4; e.data = '0;
                    exp_q.push_back(e);
                end
                if (err_idx >= ridx && err_idx < ridx + n) stop = 1'b1;
                ridx += n;
                if (!stop) begin
                    for (int k = 0; k < n; k++) begin
                        ra = s + 32'(row) * ss + 32'(w + k) * 4;
                        e.rd = 1'b0; e.addr = d + 32'(row) * ds + 32'(w + k) * 4;
                        e.data = ref_swap(mem_word(ra), sw, row[0]);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic pulse_start(input logic [31:0] s, d, input logic [15:0] lb, r,
                               input logic [31:0] ss, ds, input logic [1:0] sw);
        @(posedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d; line_bytes = lb; rows = r;
        src_stride = ss; dst_stride = ds; swap_mode = sw;
        @(posedge clk); #1;
        start = 1'b0; src_addr = '0; dst_addr = '0; line_bytes = '0; rows = '0;
    endtask

    task automatic run_xfer(input string tag, input logic [31:0] s, d, input logic [15:0] lb, r,
                            input logic [31:0] ss, ds, input logic [1:0] sw,
                            input int err_idx, input bit cd, input bit exp_err);
        int cyc;
        err_read_idx = err_idx; const_data = cd; read_idx = 0; rd_seen = 0; wr_seen = 0;
        predict(s, d, lb, r, ss, ds, sw, err_idx);
        pulse_start(s, d, lb, r, ss, ds, sw);
        cyc = 0;
        @(negedge clk);
        while (!(!busy && (done || err)) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 4000) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual busy=%0b required completion", tag, busy);
        end
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(!exp_err));
        chk({tag, "_err"},  128'(err),  128'(exp_err));
        chk({tag, "_irq"},  128'(irq),  128'(1));
        chk({tag, "_left"}, 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        @(posedge clk); #1 irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;
        @(negedge clk);
        chk({tag, "_irq_clr"}, 128'({done, err, irq}), 128'(0));
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready, busy, done, err, irq});
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int st0;
        rst = 1'b1; start = 1'b0; irq_clr = 1'b0;
        src_addr = '0; dst_addr = '0; line_bytes = '0; rows = '0;
        src_stride = '0; dst_stride = '0; swap_mode = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs(), 128'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Basic 2-row copy, no swap.
        run_xfer("basic", 32'h1000, 32'h2000, 16'd16, 16'd2, 32'd16, 32'd32, 2'b00, -1, 1'b0, 1'b0);
        chk("basic_reads", 128'(rd_seen), 128'(8));
        chk("basic_writes", 128'(wr_seen), 128'(8));

        // 6-word lines split into 4+2 bursts, full byte reverse.
        run_xfer("split", 32'h0300, 32'h8000, 16'd24, 16'd2, 32'd64, 32'd24, 2'b10, -1, 1'b0, 1'b0);
        chk("split_reads", 128'(rd_seen), 128'(12));

        // Swap only on odd rows with constant source data.
        run_xfer("oddswap", 32'h4000, 32'h5000, 16'd4, 16'd2, 32'd4, 32'd4, 2'b11, -1, 1'b1, 1'b0);

        // Error on the second read: no writes at all.
        run_xfer("rderr", 32'h1000, 32'h2000, 16'd16, 16'd2, 32'd16, 32'd32, 2'b00, 1, 1'b0, 1'b1);
        chk("rderr_writes", 128'(wr_seen), 128'(0));

        // Backpressure on the first command.
        force_stall = 3;
        st0 = stall_checks;
        run_xfer("stall", 32'h0100, 32'h0200, 16'd8, 16'd1, 32'd0, 32'd0, 2'b01, -1, 1'b0, 1'b0);
        chk("stall_seen", 128'(stall_checks - st0 >= 3), 128'(1));

        // Address wrap past 2^32.
        run_xfer("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 16'd16, 16'd2, 32'd16, 32'd8, 2'b01, -1, 1'b0, 1'b0);

        // rows = 0: done two cycles after start, no traffic.
        rd_seen = 0; wr_seen = 0;
        pulse_start(32'h1000, 32'h2000, 16'd16, 16'd0, 32'd16, 32'd16, 2'b00);
        @(negedge clk);
        chk("zero_done_c1", 128'(done), 128'(0));
        @(negedge clk);
        chk("zero_done_c2", 128'(done), 128'(1));
        chk("zero_traffic", 128'(rd_seen + wr_seen), 128'(0));
        @(posedge clk); #1 irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;

        // Reset during the write phase, then a clean transfer.
        err_read_idx = -1; const_data = 1'b0; read_idx = 0;
        predict(32'h6000, 32'h7000, 16'd16, 16'd2, 32'd16, 32'd16, 2'b00, -1);
        pulse_start(32'h6000, 32'h7000, 16'd16, 16'd2, 32'd16, 32'd16, 2'b00);
        cyc = 0;
        @(negedge clk);
        while (!(cmd_valid && !cmd_read) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reached_wr", 128'(cmd_valid && !cmd_read), 128'(1));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_outputs", all_outs(), 128'(0));
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        run_xfer("post_rst", 32'h6000, 32'h7000, 16'd16, 16'd2, 32'd16, 32'd16, 2'b10, -1, 1'b0, 1'b0);

        // Randomized transfers.
        for (int t = 0; t < 6; t++) begin
            run_xfer("rand", {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                     16'(4 * $urandom_range(1, 10)), 16'($urandom_range(1, 3)),
                     32'(4 * $urandom_range(0, 4000)), 32'(4 * $urandom_range(0, 4000)),
                     2'($urandom_range(0, 3)), -1, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_2d_engine.md
DMA_2D_ENGINE -- requirements
Module: dma_2d_engine

Interface
REQ-001 SHALL have parameter AW, default 32, meaning ICB address width.
REQ-002 SHALL have parameter DW, default 32, meaning ICB data width; legal values 32 and 64.
REQ-003 SHALL have parameter BURST, default 4, meaning maximum words per read/write burst and the internal buffer depth (power of 2, 2..16).
REQ-004 SHALL have port clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have cfg ports: start in 1 (one-cycle pulse); src_addr in AW; dst_addr in AW; line_bytes in 16; rows in 16; src_stride in AW; dst_stride in AW; swap_mode in 2 (00 none, 01 halfword-byte swap, 10 full byte reverse, 11 swap only on odd rows); irq_clr in 1.
REQ-007 SHALL have ICB master cmd ports: dma_icb_cmd_valid out 1; dma_icb_cmd_ready in 1; dma_icb_cmd_addr out AW; dma_icb_cmd_read out 1; dma_icb_cmd_wdata out DW; dma_icb_cmd_wmask out DW/8.
REQ-008 SHALL have ICB master rsp ports: dma_icb_rsp_valid in 1; dma_icb_rsp_ready out 1; dma_icb_rsp_err in 1; dma_icb_rsp_rdata in DW.
REQ-009 SHALL have status ports: busy out 1; done out 1; err out 1; dma_irq out 1 (= done | err).

Function
REQ-010 SHALL implement FSM states IDLE, RD, RD_WAIT, WR, WR_WAIT, FIN.
REQ-011 SHALL, in IDLE on start, latch all cfg inputs, assert busy next cycle, clear done/err, and go to RD; start is ignored while busy.
REQ-012 SHALL, if line_bytes or rows is zero at start, go IDLE->FIN with no ICB traffic.
REQ-013 SHALL set burst length n = min(BURST, words remaining in current line), where words = line_bytes/(DW/8); line_bytes is a multiple of DW/8.
REQ-014 SHALL, in RD, issue n read cmds at consecutive addresses (step DW/8), one per cycle, with valid held until ready; addr/read stay stable while valid and not ready; then go to RD_WAIT.
REQ-015 SHALL, in RD_WAIT, push each rsp_rdata into the buffer, then go to WR after the n-th response.
REQ-016 SHALL, in WR, issue n write cmds popping the buffer in order, wmask all ones, wdata byte-transformed per swap_mode, then go to WR_WAIT, and proceed after n write responses.
REQ-017 SHALL, at the end of each line, advance row source base by src_stride and destination base by dst_stride; after the last row go to FIN.
REQ-018 SHALL treat row index bit 0 (first row = 0, even) as the selector for swap_mode 11.
REQ-019 SHALL compute addresses modulo 2^AW (wrap silently).
REQ-020 SHALL hold dma_icb_rsp_ready = 1 in RD_WAIT and WR_WAIT, 0 otherwise.
REQ-021 SHALL, on any rsp with rsp_err = 1, set err, discard further responses of the burst, drain outstanding responses, then go to FIN without issuing new cmds.
REQ-022 SHALL, in FIN, deassert busy, set done (unless err), return to IDLE next cycle.
REQ-023 SHALL keep done/err high until irq_clr or a new accepted start; irq_clr and start in the same cycle: start wins.
REQ-024 SHALL never let more than n cmds be outstanding; the buffer never overflows or underflows.

Reset
REQ-025 SHALL, on rst, clear FSM to IDLE, buffer pointers, counters; all outputs 0 (cmd_valid, cmd_read, addr, wdata, wmask, rsp_ready, busy, done, err, dma_irq).
REQ-026 SHALL, on rst mid-transfer, abandon the transfer immediately with no further cmds; outstanding responses after reset are ignored.

Structure
REQ-027 SHALL place FSM state encoding, swap_mode codes, and the byte-swap function in shared package dma_pkg.
REQ-028 SHALL instantiate one sub-module dma_burst_fifo (depth BURST, width DW, sync rst) as the data buffer.

Verification
REQ-029 SHALL cover: src=0x1000, dst=0x2000, line_bytes=16, rows=2, strides 16/32, swap 00 -> 8 reads, 8 writes, row 1 writes at 0x2020.., done=1, irq=1.
REQ-030 SHALL cover: line_bytes=24, BURST=4 -> per-line bursts of 4 then 2 words.
REQ-031 SHALL cover: swap 11, data 0x11223344 on both rows -> row0 writes 0x11223344, row1 writes 0x22114433.
REQ-032 SHALL cover: rsp_err on 2nd read of first burst -> no writes, err=1, done=0, busy low after drain.
REQ-033 SHALL cover: cmd_ready low for 3 cycles -> cmd addr/valid stable; rows=0 start -> done in 2 cycles, no traffic.
REQ-034 SHALL cover: rst asserted mid-WR -> all outputs 0 next cycle; new start then runs a clean transfer.
